// File: rtl/m_unit.sv
`default_nettype none
// ============================================================================
// Module   : m_unit
// Function : RV32M execute-stage unit; single-cycle multiply, radix-2
//            restoring divide with divide-by-zero and overflow fast paths.
//            Define M_DIV_EARLY_EN to retire |a| < |b| divides in one cycle.
// Revision : 1.0  initial release
// ============================================================================
module m_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      op;
  logic [XLEN-1:0] quo, dvsr, rem, res_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  // Request decode, evaluated on the incoming operands
  logic            accept, is_div, sgn, a_neg, b_neg, b_zero, ovf, early, fast;
  logic [XLEN-1:0] mag_a, mag_b;

  assign accept = (state == IDLE) & start & ~flush;
  assign is_div = funct3[2];
  assign sgn    = ~funct3[0];
  assign a_neg  = sgn & src_a[XLEN-1];
  assign b_neg  = sgn & src_b[XLEN-1];
  assign mag_a  = a_neg ? -src_a : src_a;
  assign mag_b  = b_neg ? -src_b : src_b;
  assign b_zero = (src_b == '0);
  assign ovf    = sgn & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
`ifdef M_DIV_EARLY_EN
  assign early  = ~b_zero & (mag_a < mag_b);
`else
  assign early  = 1'b0;
`endif
  assign fast   = ~is_div | b_zero | ovf | early;

  // One restoring-divide step
  logic [XLEN:0] rem_sh, diff;
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr};

  // Multiply reuses quo/dvsr as operand latches; 64-bit wrap of the
  // sign-extended 33-bit operands equals the 33x33 signed product.
  logic            a_sx, b_sx;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  assign a_sx  = ((op[1:0] == 2'b01) | (op[1:0] == 2'b10)) & quo[XLEN-1];
  assign b_sx  = (op[1:0] == 2'b01) & dvsr[XLEN-1];
  assign mul_a = {{XLEN{a_sx}}, quo};
  assign mul_b = {{XLEN{b_sx}}, dvsr};
  assign prod  = mul_a * mul_b;

  logic [XLEN-1:0] fin_mul, fin_div, fin;
  assign fin_mul = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign fin_div = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  assign fin     = op[2] ? fin_div : fin_mul;

  assign done   = (state == DONE) & ~flush;
  assign result = done ? fin : res_q;
  assign stall  = accept | (state == MUL) | (state == DIV);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = fast ? DONE : DIV;
      DIV:  if (cnt == CW'(DIV_ITERS-1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op    <= '0;
      quo   <= '0;
      dvsr  <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op    <= funct3;
        cnt   <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        rem   <= '0;
        if (!is_div) begin
          quo  <= src_a;
          dvsr <= src_b;
        end else if (b_zero) begin
          quo <= '1;
          rem <= src_a;
        end else if (ovf) begin
          quo <= {1'b1, {(XLEN-1){1'b0}}};
        end else if (early) begin
          quo <= '0;
          rem <= src_a;
        end else begin
          quo   <= mag_a;
          dvsr  <= mag_b;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (state == DIV) begin
        quo <= {quo[XLEN-2:0], ~diff[XLEN]};
        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        cnt <= cnt + 1'b1;
      end
      if (done) res_q <= fin;
    end
  end

endmodule
`default_nettype wire
